// File: rtl/fp24_from_int.sv
// Three-stage converter from signed fixed-point (24-bit, 0..15 fractional bits) to fp24
// {sign, exp[6:0] bias 63, mant[15:0]} with truncation, sideband tag and global-stall handshake.
module fp24_from_int #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_int,
    input  logic [3:0]       in_frac,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_fp,
    output logic [TAG_W-1:0] out_tag
);

    // Index of the highest set bit; 0 for a zero input (callers qualify with a zero flag).
    function automatic logic [4:0] msb_index(input logic [23:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic stall;

    // Stage 1 state
    logic             s1_valid;
    logic             s1_sign;
    logic [23:0]      s1_mag;
    logic [3:0]       s1_frac;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 state
    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic [4:0]       s2_msb;
    logic [15:0]      s2_mant;
    logic [3:0]       s2_frac;
    logic [TAG_W-1:0] s2_tag;

    // Combinational stage inputs
    logic [23:0] in_mag;
    logic [4:0]  s1_msb;
    logic [4:0]  s1_shamt;
    logic [15:0] s1_mant;
    logic [6:0]  s2_exp;

    // Any held output freezes the whole pipe, so upstream sees a single ready term.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // 24-bit two's-complement negate: -2^23 maps onto 24'h800000, which is the right magnitude.
    assign in_mag   = in_int[23] ? (~in_int + 24'd1) : in_int;

    assign s1_msb   = msb_index(s1_mag);
    assign s1_shamt = 5'd23 - s1_msb;
    // Left-normalise so the leading one sits at bit 23; the mantissa is the 16 bits beneath it.
    assign s1_mant  = 16'((s1_mag << s1_shamt) >> 7);

    // Bias 63 plus MSB position minus fractional bits spans 48..86, so 7-bit arithmetic is exact.
    assign s2_exp   = 7'd63 + {2'b00, s2_msb} - {3'b000, s2_frac};

    // NOTE: data registers share the asynchronous reset with the valids so out_fp/out_tag read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_frac  <= '0;
            s1_tag   <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_sign  <= in_int[23];
            s1_mag   <= in_mag;
            s1_frac  <= in_frac;
            s1_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b1;
            s2_msb   <= '0;
            s2_mant  <= '0;
            s2_frac  <= '0;
            s2_tag   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= (s1_mag == 24'd0);
            s2_msb   <= s1_msb;
            s2_mant  <= s1_mant;
            s2_frac  <= s1_frac;
            s2_tag   <= s1_tag;
        end
    end

    // Zero magnitude packs to all-zeros so there is never a negative zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_fp    <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            out_fp    <= s2_zero ? 24'h000000 : {s2_sign, s2_exp, s2_mant};
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp24_from_int.sv
// Scoreboard bench for fp24_from_int: directed vectors push expected results, a negedge
// monitor pops and compares on every output transfer.
module tb_fp24_from_int;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_int;
    logic [3:0]       in_frac;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      out_fp;
    logic [TAG_W-1:0] out_tag;

    fp24_from_int #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .in_frac   (in_frac),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0]      fp;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_output", {8'h0, out_fp}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(out_fp == e.fp, "out_fp", {8'h0, out_fp}, {8'h0, e.fp});
                check(out_tag == e.tag, "out_tag", {24'h0, out_tag}, {24'h0, e.tag});
                if (e.lat) check(cyc == e.cyc, "latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Offer one sample, wait (bounded) for acceptance; optionally register its expected result.
    task automatic send(input logic [23:0] v, input logic [3:0] f, input logic [TAG_W-1:0] t,
                        input logic [23:0] e, input bit lat, input bit push);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_int   = v;
        in_frac  = f;
        in_tag   = t;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (push) sb.push_back('{fp: e, tag: t, cyc: cyc + 3, lat: lat});
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check(1'b0, "send_timeout", {24'h0, t}, 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Directed vectors: {in_int, in_frac, expected fp}
    typedef struct {
        logic [23:0] v;
        logic [3:0]  f;
        logic [23:0] e;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{v: 24'h000001, f: 4'd0,  e: 24'h3F0000};
        vecs[1] = '{v: 24'hFFFFFF, f: 4'd0,  e: 24'hBF0000};
        vecs[2] = '{v: 24'h000003, f: 4'd0,  e: 24'h408000};
        vecs[3] = '{v: 24'h000000, f: 4'd0,  e: 24'h000000};
        vecs[4] = '{v: 24'h7FFFFF, f: 4'd0,  e: 24'h55FFFF};
        vecs[5] = '{v: 24'h800000, f: 4'd0,  e: 24'hD60000};
        vecs[6] = '{v: 24'h000100, f: 4'd8,  e: 24'h3F0000};
        vecs[7] = '{v: 24'h000001, f: 4'd15, e: 24'h300000};
        vecs[8] = '{v: 24'h000000, f: 4'd7,  e: 24'h000000};
        vecs[9] = '{v: 24'hFFFFFD, f: 4'd1,  e: 24'hBF8000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_int    = '0;
        in_frac   = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "reset_out_valid", {31'h0, out_valid}, 32'h0);
        check(out_fp == 24'h0, "reset_out_fp", {8'h0, out_fp}, 32'h0);
        check(out_tag == '0, "reset_out_tag", {24'h0, out_tag}, 32'h0);
        check(in_ready == 1'b1, "reset_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back directed values, full throughput, latency checked.
        for (int i = 0; i < 10; i++)
            send(vecs[i].v, vecs[i].f, 8'(8'h10 + i), vecs[i].e, 1'b1, 1'b1);
        drain();

        // Backpressure: six samples, out_ready held low for 4 cycles after first out_valid.
        fork
            begin
                send(24'd1, 4'd0, 8'd1, 24'h3F0000, 1'b0, 1'b1);
                send(24'd2, 4'd0, 8'd2, 24'h400000, 1'b0, 1'b1);
                send(24'd3, 4'd0, 8'd3, 24'h408000, 1'b0, 1'b1);
                send(24'd4, 4'd0, 8'd4, 24'h410000, 1'b0, 1'b1);
                send(24'd5, 4'd0, 8'd5, 24'h414000, 1'b0, 1'b1);
                send(24'd6, 4'd0, 8'd6, 24'h418000, 1'b0, 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check(seen, "bp_first_valid", {31'h0, seen}, 32'h1);
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check(in_ready == 1'b0, "bp_in_ready", {31'h0, in_ready}, 32'h0);
                    check(out_valid == 1'b1, "bp_out_valid", {31'h0, out_valid}, 32'h1);
                    if (sb.size() != 0) begin
                        check(out_fp == sb[0].fp, "bp_frozen_fp", {8'h0, out_fp}, {8'h0, sb[0].fp});
                        check(out_tag == sb[0].tag, "bp_frozen_tag", {24'h0, out_tag}, {24'h0, sb[0].tag});
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Bubbles: alternating valid, out_valid must follow three cycles later.
        for (int i = 0; i < 14; i++) begin
            bit v_now;
            bit v_exp;
            v_now    = (i < 8) && (i % 2 == 0);
            v_exp    = (i >= 3) && (i - 3 < 8) && ((i - 3) % 2 == 0);
            in_valid = v_now;
            in_int   = 24'(i + 1);
            in_frac  = 4'd0;
            in_tag   = 8'(8'h20 + i);
            if (v_now) begin
                // i+1 is 1, 3, 5 or 7
                logic [23:0] e;
                case (i + 1)
                    1:       e = 24'h3F0000;
                    3:       e = 24'h408000;
                    5:       e = 24'h414000;
                    default: e = 24'h41C000;
                endcase
                sb.push_back('{fp: e, tag: 8'(8'h20 + i), cyc: cyc + 3, lat: 1'b1});
            end
            @(negedge clk);
            check(out_valid == v_exp, "bubble_out_valid", {31'h0, out_valid}, {31'h0, v_exp});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-stream: three samples in flight are discarded.
        send(24'd9, 4'd0, 8'h40, 24'h0, 1'b0, 1'b0);
        send(24'd9, 4'd0, 8'h41, 24'h0, 1'b0, 1'b0);
        send(24'd9, 4'd0, 8'h42, 24'h0, 1'b0, 1'b0);
        check(out_valid == 1'b1, "pre_reset_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "async_reset_valid", {31'h0, out_valid}, 32'h0);
        check(out_fp == 24'h0, "async_reset_fp", {8'h0, out_fp}, 32'h0);
        check(in_ready == 1'b1, "async_reset_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(24'h000100, 4'd4, 8'h50, 24'h430000, 1'b1, 1'b1);
        drain();

        check(sb.size() == 0, "scoreboard_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
